ahb_slave_if_pipe: RTL and testbench

Parametrised next-generation AHB slave front end for the AHB-to-APB bridge.
- Decodes a configurable number of equal-size regions.
- Delays address, write, select and valid through a configurable-depth pipeline, with write data aligned to its address.
- Inserts wait states until the APB-side controller reports completion.
- Returns a two-cycle AHB ERROR response for unmapped accesses and counts them.
- Sits between the AHB interconnect and the bridge's APB FSM.

---
 rtl/ahb_bridge_pkg.sv | 23 ++
 rtl/ahb_slave_if_pipe_if.sv | 36 +++
 rtl/ahb_pipe_reg.sv | 37 +++
 rtl/ahb_slave_if_pipe.sv | 109 ++++++++++
 tb/tb_ahb_slave_if_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_bridge_pkg.sv
// Shared AHB encodings and the slave front-end FSM state type.
package ahb_bridge_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/ahb_slave_if_pipe_if.sv
// AHB-side bus and APB-controller handshake bundle for the slave front end.
interface ahb_slave_if_pipe_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SEL = 3
) ();
    logic              hwrite;
    logic              hreadyin;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] prdata;
    logic              xfer_done;
    logic              valid;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [NUM_SEL-1:0] sel_q;
    logic              valid_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hreadyout;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;
    logic [7:0]        err_cnt;

    modport slave (
        input  hwrite, hreadyin, htrans, haddr, hwdata, prdata, xfer_done,
        output valid, addr_q, write_q, sel_q, valid_q, wdata_q,
               hreadyout, hresp, hrdata, err_cnt
    );

    modport master (
        output hwrite, hreadyin, htrans, haddr, hwdata, prdata, xfer_done,
        input  valid, addr_q, write_q, sel_q, valid_q, wdata_q,
               hreadyout, hresp, hrdata, err_cnt
    );
endinterface

// File: rtl/ahb_pipe_reg.sv
// Generic WIDTH x DEPTH delay line with synchronous reset; DEPTH=0 is a wire.
module ahb_pipe_reg #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            // Shift every stage one position per cycle.
            always_comb begin
                stage_d[0] = d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // Stage registers, cleared on reset.
            always_ff @(posedge clk) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (rst) stage_q[i] <= '0;
                    else     stage_q[i] <= stage_d[i];
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/ahb_slave_if_pipe.sv
// AHB slave front end: region decode, address pipeline, wait states, ERROR response.
module ahb_slave_if_pipe
    import ahb_bridge_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       NUM_SEL      = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter int unsigned       REGION_SHIFT = 26,
    parameter int unsigned       PIPE_DEPTH   = 2
) (
    input logic                 hclk,
    input logic                 hreset,
    ahb_slave_if_pipe_if.slave  bus
);
    localparam int unsigned PW = ADDR_W + NUM_SEL + 2;

    logic [ADDR_W-1:0]  off;
    logic [ADDR_W-1:0]  idx;
    logic               in_range;
    logic [NUM_SEL-1:0] sel;
    logic               act;
    state_e             state_q, state_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [PW-1:0]      pipe_in, pipe_out;

    // Region decode; addresses below the base are unmapped (no wrap).
    always_comb begin
        off      = bus.haddr - BASE_ADDR;
        idx      = off >> REGION_SHIFT;
        in_range = (bus.haddr >= BASE_ADDR) && (idx < ADDR_W'(NUM_SEL));
        sel      = '0;
        for (int unsigned i = 0; i < NUM_SEL; i++) begin
            if (in_range && (idx == ADDR_W'(i))) sel[i] = 1'b1;
        end
    end

    // A transfer is accepted only when the slave can take a new address phase.
    always_comb begin
        act = bus.hreadyin && bus.htrans[1] &&
              ((state_q == ST_IDLE) || (state_q == ST_ERR2) ||
               ((state_q == ST_BUSY) && bus.xfer_done));
    end

    assign bus.valid  = act && in_range;
    assign bus.hrdata = bus.prdata;

    // Next state, bus response and error counter update.
    always_comb begin
        state_d       = state_q;
        bus.hreadyout = 1'b1;
        bus.hresp     = HRESP_OKAY;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (state_q == ST_ERR2) bus.hresp = HRESP_ERROR;
                if (bus.valid)  state_d = ST_BUSY;
                else if (act)   state_d = ST_ERR1;
                else            state_d = ST_IDLE;
            end
            ST_BUSY: begin
                bus.hreadyout = bus.xfer_done;
                if (bus.xfer_done) begin
                    if (bus.valid) state_d = ST_BUSY;
                    else if (act)  state_d = ST_ERR1;
                    else           state_d = ST_IDLE;
                end
            end
            ST_ERR1: begin
                bus.hreadyout = 1'b0;
                bus.hresp     = HRESP_ERROR;
                state_d       = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase

        err_cnt_d = err_cnt_q;
        if ((state_d == ST_ERR1) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    // State and error counter registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= ST_IDLE;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
    assign pipe_in     = {bus.haddr, bus.hwrite, sel, bus.valid};
    assign {bus.addr_q, bus.write_q, bus.sel_q, bus.valid_q} = pipe_out;

    ahb_pipe_reg #(.WIDTH(PW), .DEPTH(PIPE_DEPTH)) u_addr_pipe (
        .clk (hclk),
        .rst (hreset),
        .d   (pipe_in),
        .q   (pipe_out)
    );

    // Write data arrives one cycle after its address, so it needs one stage less.
    ahb_pipe_reg #(.WIDTH(DATA_W), .DEPTH(PIPE_DEPTH - 1)) u_wdata_pipe (
        .clk (hclk),
        .rst (hreset),
        .d   (bus.hwdata),
        .q   (bus.wdata_q)
    );
endmodule

// File: tb/tb_ahb_slave_if_pipe.sv
// Self-checking bench for ahb_slave_if_pipe with a scoreboard on the pipelined outputs.
module tb_ahb_slave_if_pipe;
    logic hclk = 1'b0;
    logic hreset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int exp_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  sel;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    ahb_slave_if_pipe_if #(.ADDR_W(32), .DATA_W(32), .NUM_SEL(3)) bus ();

    ahb_slave_if_pipe #(
        .ADDR_W(32), .DATA_W(32), .NUM_SEL(3), .BASE_ADDR(32'h8000_0000),
        .REGION_SHIFT(26), .PIPE_DEPTH(2)
    ) dut (
        .hclk(hclk), .hreset(hreset), .bus(bus)
    );

    always #5 hclk = ~hclk;

    // Scoreboard: every pipelined valid must match the oldest pending transfer.
    always @(negedge hclk) begin
        if (!hreset && bus.valid_q === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: valid_q=1 addr_q=%h, required no pending transfer", bus.addr_q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.addr_q !== e.addr || bus.write_q !== e.write ||
                    bus.sel_q !== e.sel || bus.wdata_q !== e.wdata) begin
                    n_err++;
                    $display("FAIL sb_xfer: got addr=%h wr=%b sel=%b wdata=%h, required addr=%h wr=%b sel=%b wdata=%h",
                             bus.addr_q, bus.write_q, bus.sel_q, bus.wdata_q, e.addr, e.write, e.sel, e.wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_idle();
        bus.htrans    = 2'b00;
        bus.haddr     = '0;
        bus.hwrite    = 1'b0;
        bus.xfer_done = 1'b0;
        bus.hreadyin  = 1'b1;
        #1;
    endtask

    task automatic present(input logic [31:0] a, input logic wr, input logic [1:0] tr);
        bus.haddr  = a;
        bus.hwrite = wr;
        bus.htrans = tr;
        #1;
    endtask

    task automatic test_reset();
        bus.hwdata = '0;
        bus.prdata = '0;
        set_idle();
        hreset = 1'b1;
        tick(); tick();
        n_cmp++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b00 || bus.err_cnt !== 8'd0 || bus.valid_q !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got rdy=%b resp=%b cnt=%0d vq=%b, required 1 00 0 0",
                     bus.hreadyout, bus.hresp, bus.err_cnt, bus.valid_q);
        end
        hreset = 1'b0;
        present(32'h8000_0000, 1'b1, 2'b10);
        tick();
        set_idle();
        n_cmp++;
        if (bus.hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got hreadyout=%b, required 0", bus.hreadyout);
        end
        hreset = 1'b1;
        tick(); tick();
        hreset = 1'b0;
        tick();
        n_cmp++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b00 || bus.addr_q !== 32'h0 ||
            bus.valid_q !== 1'b0 || bus.err_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_after: got rdy=%b resp=%b addr_q=%h vq=%b cnt=%0d, required 1 00 0 0 0",
                     bus.hreadyout, bus.hresp, bus.addr_q, bus.valid_q, bus.err_cnt);
        end
    endtask

    task automatic test_write();
        present(32'h8400_0010, 1'b1, 2'b10);
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.hreadyout !== 1'b1) begin
            n_err++;
            $display("FAIL write_accept: got valid=%b rdy=%b, required 1 1", bus.valid, bus.hreadyout);
        end
        sb.push_back('{32'h8400_0010, 1'b1, 3'b010, 32'hDEAD_BEEF});
        tick();
        set_idle();
        bus.hwdata = 32'hDEAD_BEEF;
        n_cmp++;
        if (bus.hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL write_wait1: got hreadyout=%b, required 0", bus.hreadyout);
        end
        tick();
        bus.hwdata = '0;
        n_cmp++;
        if (bus.hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL write_wait2: got hreadyout=%b, required 0", bus.hreadyout);
        end
        bus.xfer_done = 1'b1;
        #1;
        n_cmp++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b00) begin
            n_err++;
            $display("FAIL write_done: got rdy=%b resp=%b, required 1 00", bus.hreadyout, bus.hresp);
        end
        tick();
        bus.xfer_done = 1'b0;
        #1;
        n_cmp++;
        if (sb.size() != 0 || bus.hreadyout !== 1'b1) begin
            n_err++;
            $display("FAIL write_drain: got pending=%0d rdy=%b, required 0 1", sb.size(), bus.hreadyout);
        end
    endtask

    task automatic test_unmapped();
        present(32'h8C00_0000, 1'b0, 2'b10);
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.hreadyout !== 1'b1 || bus.hresp !== 2'b00) begin
            n_err++;
            $display("FAIL unmap_phase: got valid=%b rdy=%b resp=%b, required 0 1 00", bus.valid, bus.hreadyout, bus.hresp);
        end
        tick();
        set_idle();
        exp_err = exp_err + 1;
        n_cmp++;
        if (bus.hresp !== 2'b01 || bus.hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL unmap_err1: got resp=%b rdy=%b, required 01 0", bus.hresp, bus.hreadyout);
        end
        tick();
        n_cmp++;
        if (bus.hresp !== 2'b01 || bus.hreadyout !== 1'b1) begin
            n_err++;
            $display("FAIL unmap_err2: got resp=%b rdy=%b, required 01 1", bus.hresp, bus.hreadyout);
        end
        tick();
        n_cmp++;
        if (bus.hresp !== 2'b00 || bus.hreadyout !== 1'b1 || bus.err_cnt !== 8'(exp_err)) begin
            n_err++;
            $display("FAIL unmap_idle: got resp=%b rdy=%b cnt=%0d, required 00 1 %0d",
                     bus.hresp, bus.hreadyout, bus.err_cnt, exp_err);
        end
        for (int i = 0; i < 300; i++) begin
            present(32'h8C00_0000, 1'b0, 2'b11);
            tick();
            set_idle();
            tick();
            if (exp_err < 255) exp_err = exp_err + 1;
            if (i == 252) begin
                n_cmp++;
                if (bus.err_cnt !== 8'(exp_err)) begin
                    n_err++;
                    $display("FAIL errcnt_pre_sat: got %0d, required %0d", bus.err_cnt, exp_err);
                end
            end
        end
        tick();
        n_cmp++;
        if (bus.err_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL errcnt_sat: got %0d, required 255", bus.err_cnt);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [6];
        logic [2:0]  sels  [6];
        addrs = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h87FF_FFFC, 32'h8BFF_FFFC, 32'h8400_0000, 32'hFFFF_FFFC};
        sels  = '{3'b000,        3'b001,        3'b010,        3'b100,        3'b010,        3'b000};
        for (int i = 0; i < 6; i++) begin
            present(addrs[i], 1'b0, 2'b10);
            n_cmp++;
            if (bus.valid !== (sels[i] != 3'b000)) begin
                n_err++;
                $display("FAIL bound_valid[%0h]: got %b, required %b", addrs[i], bus.valid, sels[i] != 3'b000);
            end
            if (sels[i] != 3'b000) begin
                sb.push_back('{addrs[i], 1'b0, sels[i], 32'h0});
                tick();
                set_idle();
                tick();
                bus.xfer_done = 1'b1;
                tick();
                bus.xfer_done = 1'b0;
                #1;
                n_cmp++;
                if (sb.size() != 0 || bus.hreadyout !== 1'b1) begin
                    n_err++;
                    $display("FAIL bound_drain[%0h]: got pending=%0d rdy=%b, required 0 1", addrs[i], sb.size(), bus.hreadyout);
                end
            end else begin
                tick();
                set_idle();
                n_cmp++;
                if (bus.hresp !== 2'b01 || bus.hreadyout !== 1'b0) begin
                    n_err++;
                    $display("FAIL bound_err[%0h]: got resp=%b rdy=%b, required 01 0", addrs[i], bus.hresp, bus.hreadyout);
                end
                tick(); tick();
            end
        end
    endtask

    task automatic test_non_transfers();
        logic [1:0] trs [2];
        trs = '{2'b00, 2'b01};
        bus.prdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            present(32'h8000_0000, 1'b1, trs[i]);
            n_cmp++;
            if (bus.valid !== 1'b0 || bus.hresp !== 2'b00 || bus.hreadyout !== 1'b1 || bus.hrdata !== 32'h1234_5678) begin
                n_err++;
                $display("FAIL nontrans_%0d: got valid=%b resp=%b rdy=%b hrdata=%h, required 0 00 1 12345678",
                         i, bus.valid, bus.hresp, bus.hreadyout, bus.hrdata);
            end
            tick();
            set_idle();
            n_cmp++;
            if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b00) begin
                n_err++;
                $display("FAIL nontrans_state_%0d: got rdy=%b resp=%b, required 1 00", i, bus.hreadyout, bus.hresp);
            end
        end
        bus.prdata = '0;
    endtask

    task automatic test_back_to_back();
        present(32'h8000_0000, 1'b1, 2'b10);
        sb.push_back('{32'h8000_0000, 1'b1, 3'b001, 32'h1111_1111});
        tick();
        set_idle();
        bus.hwdata = 32'h1111_1111;
        tick();
        bus.hwdata = '0;
        bus.xfer_done = 1'b1;
        present(32'h8000_0004, 1'b1, 2'b11);
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.hreadyout !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: got valid=%b rdy=%b, required 1 1", bus.valid, bus.hreadyout);
        end
        sb.push_back('{32'h8000_0004, 1'b1, 3'b001, 32'h2222_2222});
        tick();
        set_idle();
        bus.hwdata = 32'h2222_2222;
        n_cmp++;
        if (bus.hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_stay_busy: got hreadyout=%b, required 0", bus.hreadyout);
        end
        tick();
        bus.hwdata = '0;
        bus.xfer_done = 1'b1;
        present(32'h8C00_0000, 1'b0, 2'b11);
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.hreadyout !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_unmap_phase: got valid=%b rdy=%b, required 0 1", bus.valid, bus.hreadyout);
        end
        tick();
        set_idle();
        n_cmp++;
        if (bus.hresp !== 2'b01 || bus.hreadyout !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL b2b_err1: got resp=%b rdy=%b pending=%0d, required 01 0 0", bus.hresp, bus.hreadyout, sb.size());
        end
        tick(); tick();
        bus.xfer_done = 1'b1;
        tick();
        bus.xfer_done = 1'b0;
        #1;
        n_cmp++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 2'b00 || bus.valid_q !== 1'b0) begin
            n_err++;
            $display("FAIL idle_xfer_done: got rdy=%b resp=%b vq=%b, required 1 00 0", bus.hreadyout, bus.hresp, bus.valid_q);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_unmapped();
        test_boundaries();
        test_non_transfers();
        test_back_to_back();
        tick(); tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending transfers, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
